// File: rtl/vita49_trig_pkg.sv
// Shared types and helpers for the VITA49 trigger window scheduler:
// control-word bit positions, FSM states, the queued window record and time compare.
package vita49_trig_pkg;

  localparam int EN      = 0;
  localparam int RST     = 1;
  localparam int SET_ON  = 2;
  localparam int SET_OFF = 3;
  localparam int PASS    = 4;

  localparam int WIN_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_ON,
    LOAD_OFF,
    ARM,
    ACTIVE
  } sched_state_e;

  typedef struct packed {
    logic [31:0] tsi_on;
    logic [31:0] tsf_on;
    logic [31:0] tsi_off;
    logic [31:0] tsf_off;
  } window_t;

  // True when time a is at or after time b (integer seconds first, then fraction).
  function automatic logic time_ge(input logic [31:0] tsi_a, input logic [63:0] tsf_a,
                                   input logic [31:0] tsi_b, input logic [63:0] tsf_b);
    return (tsi_a > tsi_b) || ((tsi_a == tsi_b) && (tsf_a >= tsf_b));
  endfunction

  function automatic logic [31:0] ctrl_word(input sched_state_e st);
    logic [31:0] w;
    w = '0;
    case (st)
      CLEAR:       w[RST]     = 1'b1;
      LOAD_ON:     w[SET_ON]  = 1'b1;
      LOAD_OFF:    w[SET_OFF] = 1'b1;
      ARM, ACTIVE: w[EN]      = 1'b1;
      default:     w          = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/vita49_trig_win_fifo.sv
// Synchronous window queue; the head is read straight from storage, so a push
// into an empty queue only becomes visible on the following cycle.
module vita49_trig_win_fifo
  import vita49_trig_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIN_W-1:0]         wdata_i,
  output logic [WIN_W-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  window_t         mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [AW:0]     level_q;
  logic            doPush, doPop;

  // Flush wins over anything else in the same cycle, including a push.
  assign doPush  = push_i && !full_o && !flush_i;
  assign doPop   = pop_i && !empty_o && !flush_i;
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (doPush && !doPop)      level_q <= level_q + (AW+1)'(1);
      else if (doPop && !doPush) level_q <= level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/vita49_trig_sched.sv
// Sequences queued on/off windows into the trigger logic: clear, load on time,
// load off time, arm, then follow trig until the window closes or is found late.
module vita49_trig_sched
  import vita49_trig_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SETTLE = 3
) (
  input  logic                   AXIS_ACLK,
  input  logic                   AXIS_ARESET,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [31:0]            wr_tsi_on,
  input  logic [31:0]            wr_tsf_on,
  input  logic [31:0]            wr_tsi_off,
  input  logic [31:0]            wr_tsf_off,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [31:0]            tsi,
  input  logic [63:0]            tsf,
  input  logic                   trig,
  output logic [31:0]            trig_ctrl,
  output logic [31:0]            trig_tsi_up,
  output logic [31:0]            trig_tsf_hi_up,
  output logic [31:0]            trig_tsf_lo_up,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done_pulse,
  output logic                   late_pulse,
  output logic [31:0]            window_count,
  output logic [15:0]            late_count
);

  localparam int CW = $clog2(SETTLE + 1);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ctrl_q, tsiUp_q, tsfLoUp_q, windowCount_q;
  logic [15:0]   lateCount_q;
  window_t       head, wrWin;
  logic          fifoFull, fifoEmpty, pop, doneEvt, lateEvt, headLate, settled;

  assign wrWin = '{tsi_on: wr_tsi_on, tsf_on: wr_tsf_on, tsi_off: wr_tsi_off, tsf_off: wr_tsf_off};

  vita49_trig_win_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (AXIS_ACLK),
    .rst_i   (AXIS_ARESET),
    .flush_i (flush),
    .push_i  (wr_valid && wr_ready),
    .pop_i   (pop),
    .wdata_i (wrWin),
    .head_o  (head),
    .level_o (level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign headLate = !fifoEmpty && time_ge(tsi, tsf, head.tsi_off, {32'h0, head.tsf_off});
  assign settled  = (cnt_q == CW'(SETTLE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pop     = 1'b0;
    doneEvt = 1'b0;
    lateEvt = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifoEmpty) begin
          if (headLate) begin
            pop     = 1'b1;
            lateEvt = 1'b1;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (settled) begin
          cnt_d   = '0;
          state_d = fifoEmpty ? IDLE : LOAD_ON;
        end
      end
      LOAD_ON: begin
        cnt_d = cnt_q + CW'(1);
        if (settled) begin
          cnt_d   = '0;
          state_d = LOAD_OFF;
        end
      end
      LOAD_OFF: begin
        cnt_d = cnt_q + CW'(1);
        if (settled) begin
          cnt_d   = '0;
          state_d = ARM;
        end
      end
      // A window whose on time is not before its off time never fires and leaves here as late.
      ARM: begin
        if (trig) begin
          state_d = ACTIVE;
        end else if (headLate) begin
          pop     = 1'b1;
          lateEvt = 1'b1;
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!trig) begin
          pop     = 1'b1;
          doneEvt = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = CLEAR;
      cnt_d   = '0;
      pop     = 1'b0;
      doneEvt = 1'b0;
      lateEvt = 1'b0;
    end
  end

  // Control word and trigger times follow the registered state one cycle later.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ctrl_q        <= '0;
      tsiUp_q       <= '0;
      tsfLoUp_q     <= '0;
      windowCount_q <= '0;
      lateCount_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_word(state_q);
      if (state_q == LOAD_ON) begin
        tsiUp_q   <= head.tsi_on;
        tsfLoUp_q <= head.tsf_on;
      end else if (state_q == LOAD_OFF) begin
        tsiUp_q   <= head.tsi_off;
        tsfLoUp_q <= head.tsf_off;
      end
      if (doneEvt && (windowCount_q != '1)) windowCount_q <= windowCount_q + 32'd1;
      if (lateEvt && (lateCount_q != '1))   lateCount_q   <= lateCount_q + 16'd1;
    end
  end

  assign wr_ready       = !fifoFull;
  assign trig_ctrl      = ctrl_q;
  assign trig_tsi_up    = tsiUp_q;
  assign trig_tsf_hi_up = '0;
  assign trig_tsf_lo_up = tsfLoUp_q;
  assign busy           = (state_q != IDLE);
  assign done_pulse     = doneEvt;
  assign late_pulse     = lateEvt;
  assign window_count   = windowCount_q;
  assign late_count     = lateCount_q;

endmodule

// File: tb/tb_vita49_trig_sched.sv
// Directed bench for the trigger window scheduler: the bench plays both the
// processor pushing windows and the trigger logic returning trig.
module tb_vita49_trig_sched;

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESET;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_tsi_on, wr_tsf_on, wr_tsi_off, wr_tsf_off;
  logic        enable, flush, trig;
  logic [31:0] tsi;
  logic [63:0] tsf;
  logic [31:0] trig_ctrl, trig_tsi_up, trig_tsf_hi_up, trig_tsf_lo_up;
  logic [3:0]  level;
  logic        busy, done_pulse, late_pulse;
  logic [31:0] window_count;
  logic [15:0] late_count;

  int checks   = 0;
  int failures = 0;

  vita49_trig_sched #(.DEPTH(8), .SETTLE(3)) dut (
    .AXIS_ACLK      (AXIS_ACLK),
    .AXIS_ARESET    (AXIS_ARESET),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_tsi_on      (wr_tsi_on),
    .wr_tsf_on      (wr_tsf_on),
    .wr_tsi_off     (wr_tsi_off),
    .wr_tsf_off     (wr_tsf_off),
    .enable         (enable),
    .flush          (flush),
    .tsi            (tsi),
    .tsf            (tsf),
    .trig           (trig),
    .trig_ctrl      (trig_ctrl),
    .trig_tsi_up    (trig_tsi_up),
    .trig_tsf_hi_up (trig_tsf_hi_up),
    .trig_tsf_lo_up (trig_tsf_lo_up),
    .level          (level),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .late_pulse     (late_pulse),
    .window_count   (window_count),
    .late_count     (late_count)
  );

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge AXIS_ACLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one window for a single clock edge, then drops wr_valid.
  task automatic applyStimulus(input logic [31:0] onTsi, input logic [31:0] onTsf,
                               input logic [31:0] offTsi, input logic [31:0] offTsf);
    wr_tsi_on  = onTsi;
    wr_tsf_on  = onTsf;
    wr_tsi_off = offTsi;
    wr_tsf_off = offTsf;
    wr_valid   = 1'b1;
    waitCycles(1);
    wr_valid   = 1'b0;
  endtask

  initial begin
    AXIS_ARESET = 1'b1;
    wr_valid = 1'b0;
    wr_tsi_on = '0; wr_tsf_on = '0; wr_tsi_off = '0; wr_tsf_off = '0;
    enable = 1'b0; flush = 1'b0; trig = 1'b0;
    tsi = '0; tsf = '0;
    waitCycles(2);
    AXIS_ARESET = 1'b0;
    waitCycles(1);
    checkOutput("rst_ctrl", trig_ctrl, 32'h0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wcount", window_count, 32'd0);
    checkOutput("rst_lcount", 32'(late_count), 32'd0);

    // Single window on=(100,0) off=(100,500), time starting at (99,0).
    tsi = 32'd99; tsf = 64'd0;
    applyStimulus(32'd100, 32'd0, 32'd100, 32'd500);
    checkOutput("w1_level", 32'(level), 32'd1);
    checkOutput("w1_idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    waitCycles(1);
    checkOutput("w1_start_busy", 32'(busy), 32'd1);
    checkOutput("w1_start_ctrl", trig_ctrl, 32'h0);
    waitCycles(1);
    checkOutput("w1_clear_first", trig_ctrl, 32'h2);
    waitCycles(2);
    checkOutput("w1_clear_last", trig_ctrl, 32'h2);
    waitCycles(1);
    checkOutput("w1_on_ctrl", trig_ctrl, 32'h4);
    checkOutput("w1_on_tsi", trig_tsi_up, 32'd100);
    checkOutput("w1_on_tsf", trig_tsf_lo_up, 32'd0);
    waitCycles(2);
    checkOutput("w1_on_last", trig_ctrl, 32'h4);
    waitCycles(1);
    checkOutput("w1_off_ctrl", trig_ctrl, 32'h8);
    checkOutput("w1_off_tsi", trig_tsi_up, 32'd100);
    checkOutput("w1_off_tsf", trig_tsf_lo_up, 32'd500);
    waitCycles(2);
    checkOutput("w1_off_last", trig_ctrl, 32'h8);
    waitCycles(1);
    checkOutput("w1_arm_ctrl", trig_ctrl, 32'h1);
    checkOutput("w1_tsf_hi", trig_tsf_hi_up, 32'h0);
    tsi = 32'd100; tsf = 64'd10; trig = 1'b1;
    waitCycles(1);
    checkOutput("w1_active_done", 32'(done_pulse), 32'd0);
    tsf = 64'd600; trig = 1'b0;
    #1;
    checkOutput("w1_done_pulse", 32'(done_pulse), 32'd1);
    checkOutput("w1_done_nolate", 32'(late_pulse), 32'd0);
    waitCycles(1);
    checkOutput("w1_pop_level", 32'(level), 32'd0);
    checkOutput("w1_done_clear", 32'(done_pulse), 32'd0);
    checkOutput("w1_wcount", window_count, 32'd1);
    checkOutput("w1_ctrl_lag", trig_ctrl, 32'h1);
    waitCycles(1);
    checkOutput("w1_idle_ctrl", trig_ctrl, 32'h0);
    checkOutput("w1_idle_busy2", 32'(busy), 32'd0);

    // Entry already past its off time is skipped while idle.
    tsi = 32'd200; tsf = 64'd0;
    applyStimulus(32'd140, 32'd0, 32'd150, 32'd0);
    checkOutput("late_pulse_idle", 32'(late_pulse), 32'd1);
    checkOutput("late_ctrl_idle", trig_ctrl, 32'h0);
    waitCycles(1);
    checkOutput("late_level", 32'(level), 32'd0);
    checkOutput("late_lcount", 32'(late_count), 32'd1);
    checkOutput("late_pulse_gone", 32'(late_pulse), 32'd0);
    checkOutput("late_ctrl_after", trig_ctrl, 32'h0);

    // Zero-length window arms, never triggers, and is skipped exactly at its off time.
    tsi = 32'd299; tsf = 64'd0;
    applyStimulus(32'd300, 32'd0, 32'd300, 32'd0);
    waitCycles(11);
    checkOutput("zero_arm_ctrl", trig_ctrl, 32'h1);
    checkOutput("zero_arm_tsi", trig_tsi_up, 32'd300);
    checkOutput("zero_not_late", 32'(late_pulse), 32'd0);
    tsi = 32'd300;
    #1;
    checkOutput("zero_late_edge", 32'(late_pulse), 32'd1);
    checkOutput("zero_no_done", 32'(done_pulse), 32'd0);
    waitCycles(1);
    checkOutput("zero_level", 32'(level), 32'd0);
    checkOutput("zero_lcount", 32'(late_count), 32'd2);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_wcount", window_count, 32'd1);

    // Fill to full with late entries, then drain with a concurrent push.
    enable = 1'b0;
    wr_tsi_on = 32'd5; wr_tsf_on = 32'd0; wr_tsi_off = 32'd10; wr_tsf_off = 32'd0;
    wr_valid = 1'b1;
    waitCycles(8);
    checkOutput("full_level", 32'(level), 32'd8);
    checkOutput("full_ready", 32'(wr_ready), 32'd0);
    enable = 1'b1;
    #1;
    checkOutput("full_late_pulse", 32'(late_pulse), 32'd1);
    waitCycles(1);
    checkOutput("full_pop_level", 32'(level), 32'd7);
    checkOutput("full_pop_ready", 32'(wr_ready), 32'd1);
    waitCycles(1);
    checkOutput("pushpop_level", 32'(level), 32'd7);
    wr_valid = 1'b0;
    waitCycles(7);
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_lcount", 32'(late_count), 32'd11);
    checkOutput("drain_no_pulse", 32'(late_pulse), 32'd0);
    enable = 1'b0;

    // Flush while a window is active with three entries queued.
    tsi = 32'd400; tsf = 64'd0;
    wr_tsi_on = 32'd401; wr_tsf_on = 32'd0; wr_tsi_off = 32'd402; wr_tsf_off = 32'd0;
    wr_valid = 1'b1;
    waitCycles(3);
    wr_valid = 1'b0;
    checkOutput("fl_level3", 32'(level), 32'd3);
    enable = 1'b1;
    waitCycles(10);
    trig = 1'b1;
    waitCycles(1);
    checkOutput("fl_active_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    waitCycles(1);
    flush = 1'b0; trig = 1'b0;
    checkOutput("fl_level0", 32'(level), 32'd0);
    checkOutput("fl_ctrl_lag", trig_ctrl, 32'h1);
    waitCycles(1);
    checkOutput("fl_clear_first", trig_ctrl, 32'h2);
    waitCycles(2);
    checkOutput("fl_clear_last", trig_ctrl, 32'h2);
    checkOutput("fl_idle_busy", 32'(busy), 32'd0);
    waitCycles(1);
    checkOutput("fl_idle_ctrl", trig_ctrl, 32'h0);
    checkOutput("fl_wcount_kept", window_count, 32'd1);
    checkOutput("fl_lcount_kept", 32'(late_count), 32'd11);

    // Reset asserted in the middle of loading the off time.
    applyStimulus(32'd500, 32'd0, 32'd501, 32'd7);
    waitCycles(8);
    checkOutput("rs_loadoff_ctrl", trig_ctrl, 32'h8);
    checkOutput("rs_loadoff_tsi", trig_tsi_up, 32'd501);
    AXIS_ARESET = 1'b1;
    waitCycles(1);
    checkOutput("rs_ctrl", trig_ctrl, 32'h0);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    checkOutput("rs_level", 32'(level), 32'd0);
    checkOutput("rs_tsi_up", trig_tsi_up, 32'd0);
    checkOutput("rs_tsf_lo_up", trig_tsf_lo_up, 32'd0);
    checkOutput("rs_wcount", window_count, 32'd0);
    checkOutput("rs_lcount", 32'(late_count), 32'd0);
    AXIS_ARESET = 1'b0;
    enable = 1'b0;
    waitCycles(1);
    checkOutput("rs_release_ready", 32'(wr_ready), 32'd1);
    checkOutput("rs_release_ctrl", trig_ctrl, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
